// File: rtl/t_ff_pkg.sv
// Shared types and helpers for the toggle flip-flop modulo counter.
package t_ff_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int MAX_WIDTH = 16;
    localparam int MW1       = MAX_WIDTH + 1;

    // Out-of-range loads saturate at the top of the count range.
    function automatic logic [MAX_WIDTH:0] clamp_load(
        input logic [MAX_WIDTH:0] val,
        input logic [MAX_WIDTH:0] mod
    );
        return (val < mod) ? val : mod - 1'b1;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single toggle flip-flop bit with asynchronous active-high reset.
module t_ff_cell (
    input  logic clock,
    input  logic reset,
    input  logic T,
    output logic Q,
    output logic Qb
);

    logic q_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) q_q <= 1'b0;
        else       q_q <= q_q ^ T;
    end

    assign Q  = q_q;
    assign Qb = ~q_q;

endmodule

// File: rtl/t_ff_mod_counter.sv
// Modulo-N up/down counter built from a bank of toggle flip-flops,
// with clear, range-checked load, terminal count and wrap/error pulses.
module t_ff_mod_counter
    import t_ff_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam int              W1    = WIDTH + 1;
    localparam logic [WIDTH:0]  MOD_X = W1'(MODULUS);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("t_ff_mod_counter: WIDTH out of range 2..16");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
        $error("t_ff_mod_counter: MODULUS out of range 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q, qb, t, next_q;
    logic [WIDTH:0]   q_x, step_x;
    logic [MAX_WIDTH:0] ld_c;
    logic             wrap_d, wrap_q;
    logic             err_d, err_q;
    dir_e             dir_s;

    assign dir_s = dir_e'(dir);
    assign q_x   = {1'b0, q};
    assign ld_c  = clamp_load(MW1'(load_val), MW1'(MODULUS));

    // Step arithmetic carries one extra bit so MODULUS == 2**WIDTH
    // still sees the carry out of the top count.
    always_comb begin
        next_q = q;
        step_x = q_x;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        priority case (1'b1)
            clear: begin
                next_q = '0;
            end
            load: begin
                next_q = ld_c[WIDTH-1:0];
                err_d  = (ld_c != MW1'(load_val));
            end
            en: begin
                if (dir_s == DIR_UP) begin
                    step_x = q_x + 1'b1;
                    if (step_x >= MOD_X) begin
                        next_q = '0;
                        wrap_d = 1'b1;
                    end else begin
                        next_q = step_x[WIDTH-1:0];
                    end
                end else begin
                    step_x = q_x - 1'b1;
                    if (step_x[WIDTH] || q_x >= MOD_X) begin
                        next_q = LAST;
                        wrap_d = 1'b1;
                    end else begin
                        next_q = step_x[WIDTH-1:0];
                    end
                end
            end
            default: begin
                next_q = q;
            end
        endcase
    end

    assign t = next_q ^ q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clock (clock),
            .reset (reset),
            .T     (t[i]),
            .Q     (q[i]),
            .Qb    (qb[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q        = q;
    assign Qb       = qb;
    assign tc       = (dir_s == DIR_UP) ? (q == LAST) : (q == '0);
    assign wrap     = wrap_q;
    assign load_err = err_q;

    a_in_range: assert property (
        @(posedge clock) disable iff (reset) q_x < MOD_X
    );

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// Self-checking bench for t_ff_mod_counter (WIDTH=4, MODULUS=10 and 16).
module tb_t_ff_mod_counter;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       dir;
        logic [3:0] q;
        logic       wr;
        logic       er;
        logic       tc;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, dir = 1'b1, clear = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] Q, Qb, Q16, Qb16;
    logic       tc, wrap, load_err, tc16, wrap16, err16;

    int checks = 0;
    int fails  = 0;

    vec_t tbl[$];
    vec_t sb[$];

    t_ff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clock(clock), .reset(reset), .en(en), .dir(dir),
        .clear(clear), .load(load), .load_val(load_val),
        .Q(Q), .Qb(Qb), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    t_ff_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clock(clock), .reset(reset), .en(en), .dir(dir),
        .clear(clear), .load(load), .load_val(load_val),
        .Q(Q16), .Qb(Qb16), .tc(tc16), .wrap(wrap16), .load_err(err16)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic c, input logic l,
                               input logic [3:0] lv, input logic e,
                               input logic d, input logic [3:0] q,
                               input logic w, input logic er,
                               input logic t);
        vec_t r;
        r.clr = c; r.ld = l; r.lv = lv; r.en = e; r.dir = d;
        r.q = q; r.wr = w; r.er = er; r.tc = t;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        @(negedge clock);
        clear = x.clr; load = x.ld; load_val = x.lv;
        en = x.en; dir = x.dir;
        sb.push_back(x);
    endtask

    task automatic idle();
        @(negedge clock);
        clear = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 8) begin
            @(posedge clock);
            #2;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Scoreboard monitor: one expected record per sampled edge.
    always @(posedge clock) begin
        vec_t e;
        logic [3:0] eqb;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            eqb = ~e.q;
            chk("q", Q, e.q);
            chk("qb", Qb, eqb);
            chk("wrap", wrap, e.wr);
            chk("load_err", load_err, e.er);
            chk("tc", tc, e.tc);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 1; i <= 12; i++) begin
            logic [3:0] q;
            q = 4'(i % 10);
            tbl.push_back(v(0, 0, 0, 1, 1, q, i == 10, 0, q == 9));
        end
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 9, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 8, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 0, 1, 6, 0, 0, 0));
        tbl.push_back(v(0, 1, 13, 0, 1, 9, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 1, 9, 0, 0, 1));
        tbl.push_back(v(0, 1, 4, 0, 1, 4, 0, 0, 0));
        tbl.push_back(v(1, 1, 8, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, 1, 1, 7, 0, 0, 0));
        tbl.push_back(v(0, 1, 10, 0, 0, 9, 0, 1, 0));
        tbl.push_back(v(1, 1, 10, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 9, 0, 1, 9, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, 0, 1, 5, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 4, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 5, 0, 0, 0));
        tbl.push_back(v(0, 1, 3, 0, 1, 3, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 0, 0, 0, 1, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 15, 0, 1, 9, 0, 1, 1));
        tbl.push_back(v(0, 1, 15, 0, 1, 9, 0, 1, 1));

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_q", Q, 4'h0);
        chk("rst_qb", Qb, 4'hF);
        chk("rst_tc", tc, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_err", load_err, 1'b0);

        foreach (tbl[i]) drive(tbl[i]);
        idle();
        drain();

        drive(v(0, 1, 7, 0, 1, 7, 0, 0, 0));
        idle();
        drain();
        #2;
        en = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_mid_q", Q, 4'h0);
        chk("rst_mid_qb", Qb, 4'hF);
        chk("rst_mid_wrap", wrap, 1'b0);
        @(posedge clock);
        #1;
        chk("rst_hold_q", Q, 4'h0);
        @(negedge clock);
        reset = 1'b0;
        en = 1'b0;

        dir = 1'b0;
        #1;
        chk("tc_dir_down", tc, 1'b1);
        dir = 1'b1;
        #1;
        chk("tc_dir_up", tc, 1'b0);

        drive(v(0, 1, 15, 0, 1, 9, 0, 1, 1));
        @(posedge clock);
        #2;
        chk("m16_load_q", Q16, 4'hF);
        chk("m16_load_err", err16, 1'b0);
        chk("m16_tc", tc16, 1'b1);
        drive(v(0, 0, 0, 1, 1, 0, 1, 0, 0));
        @(posedge clock);
        #2;
        chk("m16_up_q", Q16, 4'h0);
        chk("m16_up_wrap", wrap16, 1'b1);
        chk("m16_noX", $isunknown({Q16, Qb16, wrap16, tc16}), 1'b0);
        drive(v(0, 0, 0, 1, 0, 9, 1, 0, 0));
        @(posedge clock);
        #2;
        chk("m16_dn_q", Q16, 4'hF);
        chk("m16_dn_wrap", wrap16, 1'b1);
        chk("m16_dn_qb", Qb16, 4'h0);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
